riscv_ctrl_branchunit: RTL
==========================

# riscv_ctrl_branchunit

Parametrised branch resolution unit for the pipelined core, sitting in the control path between fetch and execute. It resolves B-type, JAL and JALR outcomes from the ALU flags in EX and compares each outcome with the fetch-time prediction. On a mismatch it issues a registered redirect/flush. It also owns a bimodal branch history table (BHT) of saturating counters that fetch reads for its prediction.

## Interface
Parameters:
- XLEN, 32: address width.
- BHT_ENTRIES, 64: number of BHT counters; power of two, ≥ 2.
- CNT_W, 2: counter width; ≥ 2.
- MISS_W, 16: mispredict statistics counter width.

Ports (one clock; reset is synchronous and active-high):
- iclk  in  1  clock.
- irst  in  1  synchronous active-high reset.
- ifetch_pc  in  XLEN  fetch-stage PC for the BHT lookup.
- opredict_taken  out  1  prediction for ifetch_pc; combinational read of the indexed counter's MSB.
- iex_valid  in  1  EX holds a valid instruction.
- iop  in  7  EX opcode.
- ifunct3  in  3  EX funct3.
- ialu_zero, ialu_ovfl, ialu_carry, ialu_neg  in  1 each  ALU flags of the EX compare (rs1 − rs2).
- iex_pc  in  XLEN  PC of the EX instruction.
- iex_target  in  XLEN  computed branch/jump target.
- iex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- opc_src  out  1  actual taken outcome; combinational.
- oredirect  out  1  registered one-cycle flush-and-redirect pulse.
- oredirect_pc  out  XLEN  PC to refetch; valid when oredirect=1.
- omiss_cnt  out  MISS_W  saturating mispredict count.

## Operation
- BHT index is pc[IDX+1:2], with IDX = log2(BHT_ENTRIES).
- Condition decode when iop = B (7'b1100011):
  - BEQ: zero.
  - BNE: ~zero.
  - BLT: neg^ovfl.
  - BGE: ~(neg^ovfl). Equal operands take the branch.
  - BLTU: ~carry.
  - BGEU: carry.
  - funct3 010/011: not taken, no BHT update, never mispredicts.
- JAL and JALR: taken = 1. Any other opcode: taken = 0.
- opc_src = taken & eff_valid, where eff_valid = iex_valid & ~oredirect. The cycle after a redirect is wrong-path shadow and is ignored.
- Mispredict when eff_valid and taken != iex_pred_taken:
  - Next cycle: oredirect=1.
  - oredirect_pc = taken ? iex_target : iex_pc + 4 (mod 2^XLEN).
- BHT update applies only to eff_valid B-type with legal funct3:
  - Taken: increment, saturating at all-ones.
  - Not taken: decrement, saturating at zero.
  - JAL/JALR do not touch the BHT.
- omiss_cnt increments once per mispredict and saturates at all-ones without wrapping.

## Timing
- Reset values:
  - Every BHT counter = 01…1 (weakly not-taken; MSB 0, rest ones).
  - oredirect = 0, oredirect_pc = 0, omiss_cnt = 0.
  - opredict_taken therefore reads 0 after reset.
- opc_src and opredict_taken: zero latency (combinational).
- oredirect / oredirect_pc: exactly 1 cycle after the mispredicting EX cycle, held for exactly one cycle.
- BHT write occurs at the clock edge ending the EX cycle and is visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value.
- Back-to-back mispredicts are impossible: the shadow cycle masks the second one.
- irst asserted mid-operation: a pending redirect is dropped, and all state returns to reset values on that edge.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - Opcode constants B/JAL/JALR.
  - funct3 constants BEQ..BGEU.
  - The counter reset constant.
- Sub-module riscv_ctrl_bht holds the counter array:
  - One combinational read port and one synchronous saturating update port.
  - Parameters BHT_ENTRIES and CNT_W.
- Condition decode, mispredict detection, redirect register and miss counter live in the top module.

## Test plan
- Reset, then lookup any PC → opredict_taken=0, oredirect=0, omiss_cnt=0.
- BGE with zero=1, neg=0, ovfl=0, iex_pred_taken=0, iex_target=0x100 → opc_src=1; next cycle oredirect=1, oredirect_pc=0x100, omiss_cnt=1.
- BEQ at iex_pc=0x40, zero=0, predicted taken → next cycle redirect to 0x44. The EX instruction in the redirect cycle (JAL, predicted 0) produces opc_src=0, no redirect, no count.
- Four taken BNEs at pc=0x10 → counter 01→10→11→11. opredict_taken for 0x10 is 1 from the cycle after the first update. Concurrent lookup in the update cycle returns the old value.
- JALR predicted 0 at iex_pc=0xFFFF_FFFC, not taken path → redirect to iex_target. A not-taken BLTU predicted 1 at the same PC → oredirect_pc=0x0000_0000 (wrap).
- MISS_W=4, 17 mispredicts → omiss_cnt holds 0xF. irst during a redirect cycle → oredirect=0 next cycle and the BHT reads weakly not-taken.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the control-path branch logic: opcodes, funct3 codes
// and the BHT counter reset value.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic logic [31:0] cnt_reset(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/riscv_ctrl_bht.sv
// Bimodal branch history table: array of saturating counters with one
// combinational read port and one synchronous update port.
module riscv_ctrl_bht
    import riscv_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(BHT_ENTRIES)-1:0] rd_idx,
    output logic [CNT_W-1:0]               rd_cnt,
    input  logic                           upd_en,
    input  logic [$clog2(BHT_ENTRIES)-1:0] upd_idx,
    input  logic                           upd_taken
);

    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_reset(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;

    logic [CNT_W-1:0] cnt [BHT_ENTRIES];

    // Read sees the pre-update value when it collides with a same-cycle write.
    assign rd_cnt = cnt[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) cnt[i] <= CNT_RST;
        end else if (upd_en) begin
            if (upd_taken) begin
                if (cnt[upd_idx] != CNT_MAX) cnt[upd_idx] <= cnt[upd_idx] + 1'b1;
            end else begin
                if (cnt[upd_idx] != CNT_MIN) cnt[upd_idx] <= cnt[upd_idx] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_ctrl_branchunit.sv
// Branch resolution unit: resolves B/JAL/JALR in EX, compares with the fetch
// prediction, issues a registered redirect and trains the bimodal BHT.
module riscv_ctrl_branchunit
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 2,
    parameter int MISS_W      = 16
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [XLEN-1:0]   ifetch_pc,
    output logic              opredict_taken,
    input  logic              iex_valid,
    input  logic [6:0]        iop,
    input  logic [2:0]        ifunct3,
    input  logic              ialu_zero,
    input  logic              ialu_ovfl,
    input  logic              ialu_carry,
    input  logic              ialu_neg,
    input  logic [XLEN-1:0]   iex_pc,
    input  logic [XLEN-1:0]   iex_target,
    input  logic              iex_pred_taken,
    output logic              opc_src,
    output logic              oredirect,
    output logic [XLEN-1:0]   oredirect_pc,
    output logic [MISS_W-1:0] omiss_cnt
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    logic             eff_valid;
    logic             taken;
    logic             is_b;
    logic             legal;
    logic             mispredict;
    logic [CNT_W-1:0] rd_cnt;
    logic             unused_pc_bits;

    // The cycle after a redirect carries a wrong-path instruction.
    assign eff_valid = iex_valid & ~oredirect;

    always_comb begin
        taken = 1'b0;
        is_b  = 1'b0;
        legal = 1'b1;
        case (iop)
            OP_B: begin
                is_b = 1'b1;
                case (ifunct3)
                    F3_BEQ:  taken = ialu_zero;
                    F3_BNE:  taken = ~ialu_zero;
                    F3_BLT:  taken = ialu_neg ^ ialu_ovfl;
                    F3_BGE:  taken = ~(ialu_neg ^ ialu_ovfl);
                    F3_BLTU: taken = ~ialu_carry;
                    F3_BGEU: taken = ialu_carry;
                    default: legal = 1'b0;
                endcase
            end
            OP_JAL, OP_JALR: taken = 1'b1;
            default:         taken = 1'b0;
        endcase
    end

    assign opc_src    = taken & eff_valid;
    assign mispredict = eff_valid & legal & (taken != iex_pred_taken);

    riscv_ctrl_bht #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CNT_W       (CNT_W)
    ) u_bht (
        .clk       (iclk),
        .rst       (irst),
        .rd_idx    (ifetch_pc[IDX+1:2]),
        .rd_cnt    (rd_cnt),
        .upd_en    (eff_valid & is_b & legal),
        .upd_idx   (iex_pc[IDX+1:2]),
        .upd_taken (taken)
    );

    assign opredict_taken = rd_cnt[CNT_W-1];
    assign unused_pc_bits = ^{ifetch_pc[XLEN-1:IDX+2], ifetch_pc[1:0]};

    always_ff @(posedge iclk) begin
        if (irst) begin
            oredirect    <= 1'b0;
            oredirect_pc <= '0;
            omiss_cnt    <= '0;
        end else begin
            oredirect <= mispredict;
            if (mispredict) begin
                oredirect_pc <= taken ? iex_target : iex_pc + XLEN'(4);
                if (omiss_cnt != '1) omiss_cnt <= omiss_cnt + 1'b1;
            end
        end
    end

endmodule
